mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage of the 5-stage pipeline, directly downstream of the EX/MEM register.
- Consumes EX/MEM outputs and performs word loads and stores on a ready/valid data-memory port.
- Stalls the front of the pipeline while an access waits, and registers the MEM/WB pipeline outputs for the writeback stage.
- Detects misaligned, illegal and timed-out accesses and suppresses their writeback.

Parameters:
- TIMEOUT, 16, maximum cycles a request may wait for dmem_ready before it is aborted (range 2..255).
- PC_RST, 32'hffff_ffff, reset value of pc_out (bubble marker).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- pc_in  in  32  PC from EX/MEM
- mem_read_in  in  1  load
- mem_write_in  in  1  store
- mem_to_reg_in  in  1  writeback selects memory data
- reg_write_in  in  1  register write enable
- alu_out_in  in  32  ALU result / memory address
- write_data_in  in  32  store data
- rd_in  in  5  destination register
- dmem_req  out  1  access request
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word address (byte address, bits [1:0] = 0)
- dmem_wdata  out  32  store data
- dmem_ready  in  1  access complete this cycle
- dmem_rdata  in  32  load data, valid when dmem_ready = 1
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM this cycle
- pc_out  out  32  MEM/WB PC
- mem_to_reg_out  out  1  MEM/WB mem_to_reg
- reg_write_out  out  1  MEM/WB reg_write
- read_data_out  out  32  MEM/WB load data
- alu_out_out  out  32  MEM/WB ALU result
- rd_out  out  5  MEM/WB destination register
- mem_err  out  1  one-cycle pulse, registered with MEM/WB: access faulted

Behaviour:
- Reset (rst = 1 at a clk edge):
  - pc_out = PC_RST; every other registered output = 0; FSM returns to IDLE; wait counter = 0.
  - An outstanding request is dropped and dmem_req is 0 from the next cycle.
- Access classification (combinational on inputs):
  - acc = mem_read_in | mem_write_in.
  - illegal = mem_read_in & mem_write_in.
  - misal = acc & (alu_out_in[1:0] != 0).
  - fault = illegal | misal.
  - ok = acc & !fault.
- FSM states: IDLE, WAIT. A wait counter (8 bits) runs alongside.
- IDLE:
  - dmem_req = ok, dmem_we = mem_write_in, dmem_addr = alu_out_in, dmem_wdata = write_data_in.
  - ok and dmem_ready: zero-wait completion, stall = 0, MEM/WB captures this cycle; stay in IDLE.
  - ok and !dmem_ready: stall = 1, MEM/WB captures a bubble, go to WAIT, counter = 1.
  - fault: no request, stall = 0, MEM/WB captures with reg_write_out = 0 and mem_err = 1.
  - no access: pass-through, 1-cycle latency, identical to a plain pipeline register.
- WAIT:
  - dmem_req = 1. dmem_we, dmem_addr and dmem_wdata stay stable because EX/MEM is frozen by stall.
  - dmem_ready: stall = 0, MEM/WB captures the access, return to IDLE.
  - !dmem_ready and counter == TIMEOUT-1: abort. stall = 0, MEM/WB captures with reg_write_out = 0 and mem_err = 1, return to IDLE.
  - Otherwise: stall = 1, bubble into MEM/WB, counter += 1.
- Bubble definition: pc_out = PC_RST, reg_write_out = 0, mem_to_reg_out = 0, mem_err = 0. Data fields hold their previous values.
- Capture contents:
  - pc_out, mem_to_reg_out, alu_out_out and rd_out take their *_in values.
  - read_data_out = dmem_rdata on a load completion, else 0.
  - reg_write_out = reg_write_in & !fault & !aborted.
- stall is combinational: stall = ok & !dmem_ready & !(WAIT & counter == TIMEOUT-1).
- dmem_ready while dmem_req = 0 is ignored.
- Store completion captures reg_write_in unchanged (normally 0).

Decomposition:
- Shared pipeline package:
  - FSM state encoding (IDLE = 0, WAIT = 1).
  - PC_RST bubble constant.
  - Width constants: XLEN = 32, REG_W = 5.
- One sub-module, mem_wb_reg: holds the MEM/WB register, with inputs capture, bubble and err. mem_stage holds the FSM, the counter and the classification logic.

Test Plan:
- Reset then idle: pc_out = ffff_ffff, all other outputs 0, stall = 0, dmem_req = 0.
- Load lw, addr 0x100, rd = 5, dmem_ready tied 1, rdata 0xDEADBEEF -> next cycle read_data_out = DEADBEEF, rd_out = 5, reg_write_out = 1, no stall.
- Store to 0x204, data 0x1234, ready after 3 cycles -> stall = 1 for exactly 3 cycles, dmem_we = 1 stable, 3 bubbles, then completion captured with mem_err = 0.
- Load from 0x102 (misaligned) -> dmem_req = 0, stall = 0, next cycle reg_write_out = 0, mem_err = 1.
- Load with ready never asserted, TIMEOUT = 16 -> stall high 15 cycles, abort on the 16th, mem_err = 1, reg_write_out = 0, FSM back in IDLE.
- rst asserted in cycle 2 of WAIT -> next cycle dmem_req = 0, stall = 0, outputs at reset values; a late dmem_ready is ignored.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared MEM-stage types and constants: FSM encoding, MEM/WB payload, widths.
// No logic; latency/backpressure are properties of the modules that import this.
package mem_stage_pkg;

    localparam int XLEN  = 32;
    localparam int REG_W = 5;
    localparam int CNT_W = 8;

    localparam logic [XLEN-1:0] PC_RST_VAL = 32'hffff_ffff;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic             mem_to_reg;
        logic             reg_write;
        logic [XLEN-1:0]  read_data;
        logic [XLEN-1:0]  alu_out;
        logic [REG_W-1:0] rd;
    } mem_wb_t;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/response port: combinational request, ready completes it.
// The master holds request fields stable until dmem_ready is seen.
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic            dmem_ready;
    logic [XLEN-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ready, dmem_rdata
    );

endinterface

// File: rtl/mem_stage_mem_wb_reg.sv
// MEM/WB pipeline register: capture, bubble (control cleared, data held) or hold.
// One-cycle latency; err only lives for the cycle after its capture.
module mem_wb_reg
    import mem_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] PC_RST = PC_RST_VAL
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    capture,
    input  logic    bubble,
    input  logic    err,
    input  mem_wb_t cap_dat,
    output mem_wb_t wb_dat,
    output logic    mem_err
);

    mem_wb_t wb_q, wb_d;
    logic    err_q, err_d;

    always_comb begin
        wb_d  = wb_q;
        err_d = 1'b0;
        if (capture) begin
            wb_d  = cap_dat;
            err_d = err;
        end else if (bubble) begin
            wb_d.pc         = PC_RST;
            wb_d.reg_write  = 1'b0;
            wb_d.mem_to_reg = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_q    <= '0;
            wb_q.pc <= PC_RST;
            err_q   <= 1'b0;
        end else begin
            wb_q    <= wb_d;
            err_q   <= err_d;
        end
    end

    assign wb_dat  = wb_q;
    assign mem_err = err_q;

endmodule

// File: rtl/mem_stage.sv
// MEM stage: word load/store on dmem, MEM/WB register, fault and timeout detection.
// Zero-wait accesses take 1 cycle; waits assert stall and bubble MEM/WB until ready or abort.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int              TIMEOUT = 16,
    parameter logic [XLEN-1:0] PC_RST  = PC_RST_VAL
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   pc_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic              mem_to_reg_in,
    input  logic              reg_write_in,
    input  logic [XLEN-1:0]   alu_out_in,
    input  logic [XLEN-1:0]   write_data_in,
    input  logic [REG_W-1:0]  rd_in,
    mem_stage_if.master       dmem,
    output logic              stall,
    output logic [XLEN-1:0]   pc_out,
    output logic              mem_to_reg_out,
    output logic              reg_write_out,
    output logic [XLEN-1:0]   read_data_out,
    output logic [XLEN-1:0]   alu_out_out,
    output logic [REG_W-1:0]  rd_out,
    output logic              mem_err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic    acc, illegal, misal, fault, ok;
    logic    last_wait, aborted, stall_c;
    mem_wb_t cap_dat, wb_dat;

    assign acc     = mem_read_in | mem_write_in;
    assign illegal = mem_read_in & mem_write_in;
    assign misal   = acc & (alu_out_in[1:0] != 2'b00);
    assign fault   = illegal | misal;
    assign ok      = acc & ~fault;

    // The final WAIT cycle either completes or aborts; it never stalls again.
    assign last_wait = (state_q == ST_WAIT) && (cnt_q == CNT_LAST);
    assign aborted   = last_wait & ok & ~dmem.dmem_ready;
    assign stall_c   = ok & ~dmem.dmem_ready & ~last_wait;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (stall_c) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (stall_c) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // EX/MEM is frozen while waiting, so request fields come straight from the inputs.
    assign dmem.dmem_req   = (state_q == ST_WAIT) | ok;
    assign dmem.dmem_we    = mem_write_in;
    assign dmem.dmem_addr  = alu_out_in;
    assign dmem.dmem_wdata = write_data_in;

    always_comb begin
        cap_dat            = '0;
        cap_dat.pc         = pc_in;
        cap_dat.mem_to_reg = mem_to_reg_in;
        cap_dat.reg_write  = reg_write_in & ~fault & ~aborted;
        cap_dat.read_data  = (mem_read_in & ok & dmem.dmem_ready) ? dmem.dmem_rdata : '0;
        cap_dat.alu_out    = alu_out_in;
        cap_dat.rd         = rd_in;
    end

    mem_wb_reg #(
        .PC_RST (PC_RST)
    ) u_mem_wb_reg (
        .clk     (clk),
        .rst     (rst),
        .capture (~stall_c),
        .bubble  (stall_c),
        .err     (fault | aborted),
        .cap_dat (cap_dat),
        .wb_dat  (wb_dat),
        .mem_err (mem_err)
    );

    assign stall          = stall_c;
    assign pc_out         = wb_dat.pc;
    assign mem_to_reg_out = wb_dat.mem_to_reg;
    assign reg_write_out  = wb_dat.reg_write;
    assign read_data_out  = wb_dat.read_data;
    assign alu_out_out    = wb_dat.alu_out;
    assign rd_out         = wb_dat.rd;

endmodule

// File: tb/tb_mem_stage.sv
// Randomised bench for mem_stage: per-cycle expectations are queued by the stimulus
// and popped by an independent monitor; memory latency is chosen per access.
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int          TMO = 16;
    localparam logic [31:0] PCB = 32'hffff_ffff;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in, alu_out_in, write_data_in;
    logic        mem_read_in, mem_write_in, mem_to_reg_in, reg_write_in;
    logic [4:0]  rd_in;
    logic        stall, mem_to_reg_out, reg_write_out, mem_err;
    logic [31:0] pc_out, read_data_out, alu_out_out;
    logic [4:0]  rd_out;

    mem_stage_if dmem ();

    mem_stage #(.TIMEOUT(TMO), .PC_RST(PCB)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_in          (pc_in),
        .mem_read_in    (mem_read_in),
        .mem_write_in   (mem_write_in),
        .mem_to_reg_in  (mem_to_reg_in),
        .reg_write_in   (reg_write_in),
        .alu_out_in     (alu_out_in),
        .write_data_in  (write_data_in),
        .rd_in          (rd_in),
        .dmem           (dmem.master),
        .stall          (stall),
        .pc_out         (pc_out),
        .mem_to_reg_out (mem_to_reg_out),
        .reg_write_out  (reg_write_out),
        .read_data_out  (read_data_out),
        .alu_out_out    (alu_out_out),
        .rd_out         (rd_out),
        .mem_err        (mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } comb_t;

    typedef struct {
        logic [31:0] pc;
        logic        m2r;
        logic        rw;
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        err;
    } wb_t;

    comb_t cq[$];
    wb_t   rq[$];
    int    compared   = 0;
    int    mismatched = 0;

    // Model view of the MEM/WB data fields, which bubbles leave untouched.
    logic [31:0] last_rdata = '0;
    logic [31:0] last_alu   = '0;
    logic [4:0]  last_rd    = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic drive_nop();
        pc_in = PCB; mem_read_in = 0; mem_write_in = 0; mem_to_reg_in = 0;
        reg_write_in = 0; alu_out_in = '0; write_data_in = '0; rd_in = '0;
    endtask

    // One EX/MEM instruction held for as many cycles as the memory makes it wait.
    task automatic issue(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] wd,
                         input logic [4:0] rdx, input logic ld, input logic st,
                         input logic rw, input logic m2r, input int lat, input logic [31:0] rdat);
        logic acc, fault, ok, ab;
        int   s;
        wb_t  w;
        acc   = ld | st;
        fault = (ld & st) | (acc && (alu % 4 != 0));
        ok    = acc & ~fault;
        ab    = ok && (lat >= TMO);
        s     = ok ? ((lat < TMO) ? lat : TMO - 1) : 0;
        for (int k = 0; k <= s; k++) begin
            @(negedge clk);
            pc_in = pc; alu_out_in = alu; write_data_in = wd; rd_in = rdx;
            mem_read_in = ld; mem_write_in = st; reg_write_in = rw; mem_to_reg_in = m2r;
            dmem.dmem_rdata = (k == s) ? rdat : $urandom;
            dmem.dmem_ready = ok ? (k == lat) : 1'($urandom_range(0, 1));
            cq.push_back('{k < s, ok, st, alu, wd});
            if (k < s) begin
                w = '{PCB, 1'b0, 1'b0, last_rdata, last_alu, last_rd, 1'b0};
            end else begin
                w.pc    = pc;
                w.m2r   = m2r;
                w.rw    = rw & ~fault & ~ab;
                w.rdata = (ld && ok && !ab) ? rdat : 32'h0;
                w.alu   = alu;
                w.rd    = rdx;
                w.err   = fault | ab;
                last_rdata = w.rdata; last_alu = alu; last_rd = rdx;
            end
            rq.push_back(w);
        end
    endtask

    initial begin : monitor
        comb_t c;
        wb_t   w;
        forever begin
            @(negedge clk);
            #2;
            if (cq.size() > 0) begin
                c = cq.pop_front();
                check("stall", 32'(stall), 32'(c.stall));
                check("dmem_req", 32'(dmem.dmem_req), 32'(c.req));
                if (c.req) begin
                    check("dmem_we", 32'(dmem.dmem_we), 32'(c.we));
                    check("dmem_addr", dmem.dmem_addr, c.addr);
                    check("dmem_wdata", dmem.dmem_wdata, c.wdata);
                end
            end
            @(posedge clk);
            #1;
            if (rq.size() > 0) begin
                w = rq.pop_front();
                check("pc_out", pc_out, w.pc);
                check("mem_to_reg_out", 32'(mem_to_reg_out), 32'(w.m2r));
                check("reg_write_out", 32'(reg_write_out), 32'(w.rw));
                check("read_data_out", read_data_out, w.rdata);
                check("alu_out_out", alu_out_out, w.alu);
                check("rd_out", 32'(rd_out), 32'(w.rd));
                check("mem_err", 32'(mem_err), 32'(w.err));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [31:0] a, p;
        int          kind, r, lat;
        rst = 1'b1;
        drive_nop();
        dmem.dmem_ready = 1'b0;
        dmem.dmem_rdata = '0;
        repeat (3) @(negedge clk);
        #2;
        check("rst_pc_out", pc_out, PCB);
        check("rst_reg_write", 32'(reg_write_out), 32'h0);
        check("rst_mem_to_reg", 32'(mem_to_reg_out), 32'h0);
        check("rst_read_data", read_data_out, 32'h0);
        check("rst_alu_out", alu_out_out, 32'h0);
        check("rst_rd_out", 32'(rd_out), 32'h0);
        check("rst_mem_err", 32'(mem_err), 32'h0);
        check("rst_stall", 32'(stall), 32'h0);
        check("rst_dmem_req", 32'(dmem.dmem_req), 32'h0);
        rst = 1'b0;

        // Directed cases, then a random mix through the same path.
        issue(32'h1000, 32'h100, 32'h0,    5'd5, 1, 0, 1, 1, 0,       32'hDEADBEEF);
        issue(32'h1004, 32'h204, 32'h1234, 5'd0, 0, 1, 0, 0, 3,       32'h0);
        issue(32'h1008, 32'h102, 32'h0,    5'd6, 1, 0, 1, 1, 0,       32'h5555AAAA);
        issue(32'h100C, 32'h108, 32'h0,    5'd7, 1, 0, 1, 1, 1000,    32'h1111);
        issue(32'h1010, 32'h10C, 32'h0,    5'd8, 1, 0, 1, 1, TMO - 1, 32'hCAFEF00D);
        issue(32'h1014, 32'h110, 32'h99,   5'd9, 1, 1, 1, 0, 0,       32'h2222);
        issue(32'h1018, 32'h114, 32'h0,    5'd3, 0, 0, 1, 0, 0,       32'h3333);

        for (int n = 0; n < 250; n++) begin
            kind = $urandom_range(0, 9);
            a = $urandom; a[1:0] = 2'b00;
            p = $urandom; p[1:0] = 2'b00;
            r = $urandom_range(0, 19);
            if (r < 8)       lat = 0;
            else if (r < 17) lat = r - 7;
            else             lat = TMO - 1 + $urandom_range(0, 3);
            if (kind == 8) a[1:0] = 2'($urandom_range(1, 3));
            issue(p, a, $urandom, 5'($urandom), (kind >= 3 && kind <= 5) || kind >= 8,
                  kind == 6 || kind == 7 || kind == 9 || (kind == 8 && r[0]),
                  1'($urandom), 1'($urandom), lat, $urandom);
        end

        // Reset in the second WAIT cycle; a late ready afterwards must be ignored.
        @(negedge clk);
        pc_in = 32'h40; alu_out_in = 32'h300; mem_read_in = 1; mem_write_in = 0;
        reg_write_in = 1; mem_to_reg_in = 1; rd_in = 5'd4; dmem.dmem_ready = 0;
        #2 check("rw_stall_idle", 32'(stall), 32'h1);
        @(negedge clk);
        #2 check("rw_stall_wait1", 32'(stall), 32'h1);
        check("rw_req_wait1", 32'(dmem.dmem_req), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        #2 check("rw_stall_wait2", 32'(stall), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        drive_nop();
        dmem.dmem_ready = 1'b1;
        dmem.dmem_rdata = 32'hBADC0DE0;
        #2;
        check("rw_req_after_rst", 32'(dmem.dmem_req), 32'h0);
        check("rw_stall_after_rst", 32'(stall), 32'h0);
        check("rw_pc_after_rst", pc_out, PCB);
        check("rw_rw_after_rst", 32'(reg_write_out), 32'h0);
        check("rw_err_after_rst", 32'(mem_err), 32'h0);
        check("rw_alu_after_rst", alu_out_out, 32'h0);
        @(negedge clk);
        dmem.dmem_ready = 1'b0;
        #2;
        check("late_ready_rdata", read_data_out, 32'h0);
        check("late_ready_rw", 32'(reg_write_out), 32'h0);
        check("late_ready_err", 32'(mem_err), 32'h0);
        check("late_ready_pc", pc_out, PCB);
        check("wb_queue_drained", 32'(rq.size()), 32'h0);
        check("comb_queue_drained", 32'(cq.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
